// File: rtl/z80_incdec_rmw_seq.sv
// Execution sequencer for INC/DEC r and INC/DEC (HL): one-cycle register
// read-modify-write, or a 4T memory read followed by a 3T memory write.
module z80_incdec_rmw_seq #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        insn,
  input  logic [ADDR_W-1:0] hl,
  input  logic [7:0]        f_in,
  output logic [2:0]        reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              reg_we,
  output logic [2:0]        reg_waddr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              f_we,
  output logic [7:0]        f_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_mreq,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din,
  input  logic              mem_wait,
  output logic              busy,
  output logic              done,
  output logic [4:0]        t_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_EXEC,
    S_RD_T1, S_RD_T2, S_RD_T3, S_RD_T4,
    S_WR_T1, S_WR_T2, S_WR_T3
  } state_t;

  function automatic logic [DATA_W-1:0] inc_dec(input logic [DATA_W-1:0] opnd,
                                                input logic dec);
    return dec ? opnd - DATA_W'(1) : opnd + DATA_W'(1);
  endfunction

  function automatic logic [7:0] calc_flags(input logic [DATA_W-1:0] opnd,
                                            input logic [DATA_W-1:0] res,
                                            input logic dec,
                                            input logic [2:0] fk);
    logic h;
    logic v;
    h = dec ? (opnd[3:0] == 4'h0) : (opnd[3:0] == 4'hF);
    v = dec ? (opnd == {1'b1, {(DATA_W-1){1'b0}}})
            : (opnd == {1'b0, {(DATA_W-1){1'b1}}});
    return {res[DATA_W-1], (res == '0), fk[2], h, fk[1], v, dec, fk[0]};
  endfunction

  function automatic logic [4:0] sat_tcount(input logic [4:0] waits);
    logic [5:0] sum;
    sum = 6'd11 + {1'b0, waits};
    return (sum > 6'd31) ? 5'd31 : sum[4:0];
  endfunction

  state_t              state_q, state_d;
  logic [4:0]          waits_q, waits_d;
  logic [2:0]          r_q, r_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                reg_we_q, reg_we_d;
  logic                f_we_q, f_we_d;
  logic                mreq_q, mreq_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_dout_q, mem_dout_d;
  logic [4:0]          t_count_q, t_count_d;

  logic [ADDR_W-1:0]   hl_q;
  logic [2:0]          fk_q;
  logic                dec_q;
  logic [DATA_W-1:0]   opnd_q;

  logic                is_incdec;
  logic                accept;
  logic [DATA_W-1:0]   operand;
  logic [DATA_W-1:0]   result;
  logic [7:0]          flags;
  logic                unused_f_in;

  assign is_incdec   = (insn[7:6] == 2'b00) && (insn[2:1] == 2'b10);
  assign accept      = (state_q == S_IDLE) && start && is_incdec;
  assign unused_f_in = ^{f_in[7:6], f_in[4], f_in[2:1]};

  // Register forms take the operand straight from the register file in EXEC.
  assign operand = (state_q == S_EXEC) ? reg_rdata : opnd_q;
  assign result  = inc_dec(operand, dec_q);
  assign flags   = calc_flags(operand, result, dec_q, fk_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = (insn[5:3] == 3'd6) ? S_RD_T1 : S_EXEC;
      S_EXEC:  state_d = S_IDLE;
      S_RD_T1: state_d = S_RD_T2;
      S_RD_T2: if (!mem_wait) state_d = S_RD_T3;
      S_RD_T3: state_d = S_RD_T4;
      S_RD_T4: state_d = S_WR_T1;
      S_WR_T1: state_d = S_WR_T2;
      S_WR_T2: if (!mem_wait) state_d = S_WR_T3;
      S_WR_T3: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    waits_d = waits_q;
    if (accept) begin
      waits_d = '0;
    end else if ((state_q == S_RD_T2 || state_q == S_WR_T2) && mem_wait &&
                 (waits_q != 5'd31)) begin
      waits_d = waits_q + 5'd1;
    end

    r_d      = accept ? insn[5:3] : r_q;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_EXEC) || (state_d == S_WR_T3);
    reg_we_d = (state_d == S_EXEC);
    f_we_d   = done_d;
    rd_d     = state_d inside {S_RD_T1, S_RD_T2, S_RD_T3};
    wr_d     = state_d inside {S_WR_T2, S_WR_T3};
    mreq_d   = rd_d || (state_d inside {S_WR_T1, S_WR_T2, S_WR_T3});

    // Address stays on the bus for the whole M2/M3 window, T4 included.
    mem_addr_d = '0;
    if (state_d inside {S_RD_T1, S_RD_T2, S_RD_T3, S_RD_T4, S_WR_T1, S_WR_T2, S_WR_T3})
      mem_addr_d = accept ? hl : hl_q;
    mem_dout_d = (state_d inside {S_WR_T1, S_WR_T2, S_WR_T3}) ? result : '0;

    t_count_d = 5'd0;
    if (state_d == S_EXEC)       t_count_d = 5'd4;
    else if (state_d == S_WR_T3) t_count_d = sat_tcount(waits_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      waits_q    <= '0;
      r_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      reg_we_q   <= 1'b0;
      f_we_q     <= 1'b0;
      mreq_q     <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
      t_count_q  <= '0;
    end else begin
      state_q    <= state_d;
      waits_q    <= waits_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      reg_we_q   <= reg_we_d;
      f_we_q     <= f_we_d;
      mreq_q     <= mreq_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      mem_addr_q <= mem_addr_d;
      mem_dout_q <= mem_dout_d;
      t_count_q  <= t_count_d;
    end
  end

  // Operand snapshot: only meaningful while the matching strobe is high.
  always_ff @(posedge clk) begin
    if (accept) begin
      hl_q  <= hl;
      fk_q  <= {f_in[5], f_in[3], f_in[0]};
      dec_q <= insn[0];
    end
    if (state_q == S_RD_T3) opnd_q <= mem_din;
  end

  assign reg_raddr = r_q;
  assign reg_waddr = r_q;
  assign reg_we    = reg_we_q;
  assign reg_wdata = reg_we_q ? result : '0;
  assign f_we      = f_we_q;
  assign f_out     = f_we_q ? flags : 8'h00;
  assign mem_addr  = mem_addr_q;
  assign mem_mreq  = mreq_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_dout  = mem_dout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign t_count   = t_count_q;

endmodule
